mul_unit: RTL
=============

# mul_unit

Iterative 8-bit multiply unit that sits directly downstream of the 8×8 register file. It takes the two register read ports as operands and computes the product over a fixed 8 cycles of shift-and-add. It then hands the low byte back to the register file's write port with a single-cycle write strobe. It extends the processor with a multi-cycle `mul` instruction without lengthening the combinational ALU path.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; the register file word size.
- `ADDR_W`, 3, register address width.

Ports:
- `CLK`  in  1  clock; all state changes on posedge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `START`  in  1  request; sampled only in IDLE.
- `OPERAND1`  in  WIDTH  multiplicand; from register file OUT1.
- `OPERAND2`  in  WIDTH  multiplier; from register file OUT2.
- `DESTADDR`  in  ADDR_W  destination register.
- `RESULT`  out  WIDTH  low byte of the product; drives register file IN.
- `WRADDR`  out  ADDR_W  latched DESTADDR; drives register file INADDRESS.
- `WRITE`  out  1  one-cycle write strobe to the register file.
- `BUSY`  out  1  high from accept to end of writeback.
- `OVERFLOW`  out  1  full product does not fit in WIDTH bits; valid with WRITE, held until the next accept.

## Operation
- Reset (RESET=0, any time, asynchronous):
  - State returns to IDLE.
  - `RESULT`, `WRADDR`, `OVERFLOW`, internal accumulator and counter all go to 0.
  - `WRITE` = 0 and `BUSY` = 0.
  - An in-flight operation is discarded and never written.
- States:
  - IDLE: on `START`=1 at a posedge:
    - latch `OPERAND1`, `OPERAND2`, `DESTADDR`;
    - clear the 2×WIDTH accumulator and load counter = WIDTH;
    - go to RUN.
  - RUN: each cycle:
    - if the multiplier LSB = 1, add the multiplicand to the upper half of the accumulator;
    - shift the accumulator and the multiplier right by 1;
    - decrement the counter.
    - When the counter reaches 0, go to WB.
  - WB: for one cycle:
    - `WRITE`=1, `RESULT`=acc[WIDTH-1:0], `OVERFLOW` updated;
    - next state is IDLE.
- Arithmetic:
  - The accumulator is 2×WIDTH bits, plus one carry bit during the add; no intermediate truncation.
  - Unsigned overflow: acc[2W-1:W] ≠ 0.
- Handshake:
  - `START` while `BUSY`=1 is ignored; the caller must re-assert it.
  - Operands are only sampled on accept; changing them mid-operation has no effect.
- Operand value has no effect on latency; zero operands still take the full 8 RUN cycles.
- `RESULT`/`WRADDR` hold their last written values while IDLE; `WRITE` is the only qualifier.

## Timing
- Accept edge = cycle 0.
- `BUSY` rises after edge 0 and stays high through the WB cycle.
- RUN covers cycles 1–8; WB is cycle 9.
- `WRITE` is high for exactly one cycle, between edges 9 and 10.
  - The register file captures `RESULT` on edge 10.
  - `RESULT`/`WRADDR` are stable for that whole cycle.
- `BUSY` falls after edge 10.
- A new `START` is accepted at the earliest on edge 10, so back-to-back throughput is one result per 10 cycles.
- `START` held high continuously restarts on edge 10 with the operands present at that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MUL_SIGNED_EN` defined:
  - Operands are two's complement.
  - On accept, absolute values are latched and the sign is recorded as OPERAND1[W-1] XOR OPERAND2[W-1].
  - RUN is unchanged.
  - In WB the 2W-bit product is negated if the sign is 1.
  - `OVERFLOW`=1 when the product is outside −128..127, i.e. the high byte is not all copies of bit W-1.
  - −128 × −128 produces 0x00 with OVERFLOW=1.
  - Latency is unchanged.
- `MUL_SIGNED_EN` undefined:
  - Pure unsigned multiply, with no sign logic synthesized.

## Structure
- Shared package (`cpu_pkg`):
  - state encoding typedef: IDLE=2'b00, RUN=2'b01, WB=2'b10;
  - `WORD_W`=8 and `REG_ADDR_W`=3, shared with the register file and ALU;
  - `MUL_CYCLES`=8.
- One natural sub-module: `mul_datapath`, holding the accumulator, multiplier shift register, adder and counter.
- The top level keeps the FSM, output registers and sign handling.

## Test plan
- Reset: pulse RESET low mid-RUN (cycle 4 of 3×5) -> all outputs are 0 immediately, and no WRITE pulse ever follows.
- Basic: OPERAND1=5, OPERAND2=7, DESTADDR=3, START at edge 0 -> WRITE is high only in cycle 9 with RESULT=0x23, WRADDR=3, OVERFLOW=0.
- Overflow unsigned: 0x10 × 0x10 -> RESULT=0x00, OVERFLOW=1; 0xFF × 0x01 -> RESULT=0xFF, OVERFLOW=0.
- Busy ignore: START again at cycle 3 with 9×9 -> exactly one WRITE (the first op), and BUSY falls after edge 10.
- Back-to-back: START held high with 2×3 and then 4×4 -> WRITEs in cycles 9 and 19 with 0x06 and 0x10.
- Signed (`MUL_SIGNED_EN`):
  - 0xFD (−3) × 0x05 -> RESULT=0xF1, OVERFLOW=0.
  - 0x80 × 0x80 -> RESULT=0x00, OVERFLOW=1.
  - 0x0C × 0x0B (132) -> RESULT=0x84, OVERFLOW=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the register file, ALU and mul_unit.
//   WORD_W      register file word width
//   REG_ADDR_W  register address width
//   MUL_CYCLES  shift-and-add iterations per multiply
//   mul_state_t encoding of the multiply controller states
package cpu_pkg;

  localparam int WORD_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int MUL_CYCLES = 8;

  typedef logic [1:0] mul_state_t;

  localparam mul_state_t ST_IDLE = 2'b00;
  localparam mul_state_t ST_RUN  = 2'b01;
  localparam mul_state_t ST_WB   = 2'b10;

endpackage

// File: rtl/mul_datapath.sv
// mul_datapath: shift-and-add core of mul_unit.
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset
//   load       clear the accumulator, latch operands, load counter = WIDTH
//   step       perform one shift-and-add iteration (ignored once the counter is 0)
//   mcand_in   multiplicand to latch on load
//   mplier_in  multiplier to latch on load
//   product    full 2*WIDTH-bit accumulator
//   last_step  counter is at 1: the step taken this cycle is the final one
module mul_datapath
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic [2*WIDTH-1:0] product,
  output logic               last_step
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     sum;

  // Upper-half add keeps its carry so the following shift loses nothing.
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= mcand_in;
      mplier <= mplier_in;
      cnt    <= CNT_W'(WIDTH);
    end else if (step && (cnt != '0)) begin
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  assign product   = acc;
  assign last_step = (cnt == CNT_W'(1));

endmodule

// File: rtl/mul_unit.sv
// mul_unit: iterative multiplier feeding the register file write port.
//   CLK       clock, all state on posedge
//   RESET     asynchronous active-low reset
//   START     request, sampled only in IDLE
//   OPERAND1  multiplicand (register file OUT1)
//   OPERAND2  multiplier (register file OUT2)
//   DESTADDR  destination register
//   RESULT    low word of the product (register file IN)
//   WRADDR    destination of the write (register file INADDRESS)
//   WRITE     one-cycle write strobe
//   BUSY      high from accept through the end of writeback
//   OVERFLOW  product does not fit in WIDTH bits; valid with WRITE
// Build option MUL_SIGNED_EN: two's complement operands and signed overflow.
// Without it the unit is a pure unsigned multiplier.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for START; outputs hold last write
// ST_RUN  | WIDTH shift-and-add iterations in the datapath
// ST_WB   | register product, raise WRITE for one cycle
module mul_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [WIDTH-1:0]  OPERAND1,
  input  logic [WIDTH-1:0]  OPERAND2,
  input  logic [ADDR_W-1:0] DESTADDR,
  output logic [WIDTH-1:0]  RESULT,
  output logic [ADDR_W-1:0] WRADDR,
  output logic              WRITE,
  output logic              BUSY,
  output logic              OVERFLOW
);

  mul_state_t         state;
  logic [ADDR_W-1:0]  dest_q;
  logic               accept;
  logic               last_step;
  logic [WIDTH-1:0]   mcand_in;
  logic [WIDTH-1:0]   mplier_in;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod;
  logic               ovf;

  assign accept = (state == ST_IDLE) && START;

`ifdef MUL_SIGNED_EN
  logic sign_q;

  // Magnitudes go through the unsigned core; -2^(W-1) maps to 2^(W-1),
  // which still fits in WIDTH unsigned bits.
  always_comb begin
    mcand_in  = OPERAND1[WIDTH-1] ? -OPERAND1 : OPERAND1;
    mplier_in = OPERAND2[WIDTH-1] ? -OPERAND2 : OPERAND2;
    prod      = sign_q ? -acc : acc;
    ovf       = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sign_q <= 1'b0;
    end else if (accept) begin
      sign_q <= OPERAND1[WIDTH-1] ^ OPERAND2[WIDTH-1];
    end
  end
`else
  always_comb begin
    mcand_in  = OPERAND1;
    mplier_in = OPERAND2;
    prod      = acc;
    ovf       = |acc[2*WIDTH-1:WIDTH];
  end
`endif

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (CLK),
    .rst_n     (RESET),
    .load      (accept),
    .step      (state == ST_RUN),
    .mcand_in  (mcand_in),
    .mplier_in (mplier_in),
    .product   (acc),
    .last_step (last_step)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      dest_q   <= '0;
      RESULT   <= '0;
      WRADDR   <= '0;
      WRITE    <= 1'b0;
      BUSY     <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      WRITE <= 1'b0;
      case (state)
        ST_IDLE: begin
          // BUSY stays up through the cycle after WB; a START on that
          // edge is a legal back-to-back accept.
          if (START) begin
            state    <= ST_RUN;
            dest_q   <= DESTADDR;
            BUSY     <= 1'b1;
            OVERFLOW <= 1'b0;
          end else begin
            BUSY <= 1'b0;
          end
        end
        ST_RUN: begin
          if (last_step) begin
            state <= ST_WB;
          end
        end
        ST_WB: begin
          WRITE    <= 1'b1;
          RESULT   <= prod[WIDTH-1:0];
          WRADDR   <= dest_q;
          OVERFLOW <= ovf;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
